counter_2digit_down: RTL and testbench
======================================

# counter_2digit_down

Two-digit BCD down-counter: the decrementing counterpart of the team's two-digit up-counter (`dig1`/`dig0`), used as a countdown timer in the lab designs. It loads a BCD start value, counts down one step per `PRESCALE` enabled clocks, and flags arrival at 00. Its outputs drive the same two-digit display path as the up-counter.

## Interface
- `PRESCALE`, default 1: number of enabled clocks per decrement step; legal range is 1..65535.
- `WRAP`, default 0: at 00, 0 holds the count and 1 wraps it to 99.
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `load`, in, 1: synchronous load of `load_dig1`/`load_dig0`.
- `load_dig1`, in, 4: BCD tens digit to load.
- `load_dig0`, in, 4: BCD ones digit to load.
- `enable`, in, 1: count enable; gates the prescaler.
- `dig1`, out, 4: registered BCD tens digit.
- `dig0`, out, 4: registered BCD ones digit.
- `zero`, out, 1: high when `dig1`==0 and `dig0`==0; derived from registers.
- `done`, out, 1: registered one-cycle pulse when a decrement step lands on 00.

## Operation
- Priority: `reset` > `load` > count step.
- Reset is asynchronous.
  - Values: `dig1`=0, `dig0`=0, prescaler=0, `done`=0, so `zero`=1.
  - Release is synchronous to `clock`; the first action can occur on the first rising edge after deassertion.
- Load:
  - `load`=1 on an edge: `dig1`<=`load_dig1` and `dig0`<=`load_dig0`, with any digit >9 clamped to 9.
  - Prescaler is cleared and `done` is 0 that cycle.
  - `load` overrides `enable` in the same cycle.
- Prescaler:
  - When `enable`=1 and `load`=0, the prescaler counts 0..`PRESCALE`-1.
  - A step fires on the edge where the prescaler equals `PRESCALE`-1; the prescaler then returns to 0.
  - When `enable`=0, the prescaler holds its value and no step occurs.
  - With `PRESCALE`=1, a step fires on every enabled edge.
- Step, count != 00:
  - If `dig0`!=0: `dig0`<=`dig0`-1.
  - Otherwise: `dig0`<=9 and `dig1`<=`dig1`-1.
- Step, count == 00:
  - `WRAP`=0: digits hold, `done` stays 0, and the prescaler keeps cycling with no effect.
  - `WRAP`=1: count goes to 99 and `done` stays 0.
- Done:
  - `done`<=1 on the edge where a step changes the count from 01 to 00. On every other edge, `done`<=0.
  - Loading 00 never asserts `done`.
  - Under `WRAP`=1, `done` pulses once per pass through 00.
- Digits are always valid BCD (0..9). No intermediate non-BCD value is ever visible.

## Timing
- Load latency: 1 clock. New digits are visible after the edge where `load` is sampled high.
- Step period: `PRESCALE` enabled clocks. Disabled clocks stretch the period without losing prescaler progress.
- `done` and `zero` rise together after the 01->00 edge. `done` falls on the next edge; `zero` stays high while the count is 00.
- Reset mid-count: outputs go to reset values immediately, without waiting for a clock edge. A pending `done` is cancelled.
- `load` on the same edge as a 01->00 step: the load wins and `done`=0.
- `enable` deasserted on a step edge: no step occurs and the prescaler holds at `PRESCALE`-1.
- `load_dig*` are sampled only on edges where `load`=1.

## Test plan
- Reset: assert `reset` for 100 ns with `clock` at 20 ns period -> `dig1`=0, `dig0`=0, `zero`=1, `done`=0 during reset and after release.
- Basic countdown (`PRESCALE`=1, `WRAP`=0):
  - Stimulus: load 12, then hold `enable`=1.
  - Sequence: 11, 10, 09, ..., 01, 00.
  - `done`=1 for exactly one cycle at 00, then the count holds at 00 with `done`=0.
- Prescale and gating (`PRESCALE`=4):
  - Stimulus: load 05, `enable`=1, drop `enable` for 3 clocks mid-period.
  - Required: each step takes 4 enabled clocks, the gap adds 3 clocks, and 04 is reached after 7 clocks.
- Wrap (`WRAP`=1):
  - Stimulus: load 01 and enable.
  - Required: 00 with a `done` pulse, then 99, 98, and so on; a second `done` pulse at the next 00.
- Clamp and collision:
  - Load `load_dig1`=4'hC, `load_dig0`=4'hF -> count becomes 99.
  - Count to 01 and assert `load` with value 30 on the step edge -> count becomes 30 and `done` stays 0.
- Async reset mid-count: assert `reset` between edges while the count is 57 -> digits go to 00 before the next edge and `done` stays 0.

Source files
------------

// File: rtl/counter_2digit_down.sv
// Two-digit BCD down-counter with prescaled step, load with digit clamp,
// optional wrap from 00 to 99, and a one-cycle done pulse on reaching 00.
module counter_2digit_down #(
   parameter int PRESCALE = 1,
   parameter bit WRAP     = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_dig1,
   input  logic [3:0] load_dig0,
   input  logic       enable,
   output logic [3:0] dig1,
   output logic [3:0] dig0,
   output logic       zero,
   output logic       done
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] presc;
   logic        step;

   // Digits above 9 are forced to 9 so the display never sees a non-BCD value.
   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // A step fires only on an enabled edge where the prescaler has reached its last count.
   always_comb begin
      step = enable && (presc == LAST);
   end

   // Zero is decoded straight from the digit registers.
   always_comb begin
      zero = (dig1 == 4'd0) && (dig0 == 4'd0);
   end

   // Digit, prescaler and done registers; load beats counting, reset beats both.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dig1  <= 4'd0;
         dig0  <= 4'd0;
         presc <= 16'd0;
         done  <= 1'b0;
      end else if (load) begin
         dig1  <= clamp_bcd(load_dig1);
         dig0  <= clamp_bcd(load_dig0);
         presc <= 16'd0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (enable) begin
            presc <= step ? 16'd0 : presc + 16'd1;
         end
         if (step) begin
            if (dig0 != 4'd0) begin
               dig0 <= dig0 - 4'd1;
               // Only the 01 -> 00 transition raises done.
               done <= (dig1 == 4'd0) && (dig0 == 4'd1);
            end else if (dig1 != 4'd0) begin
               dig0 <= 4'd9;
               dig1 <= dig1 - 4'd1;
            end else if (WRAP) begin
               dig1 <= 4'd9;
               dig0 <= 4'd9;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_2digit_down.sv
// Directed bench for counter_2digit_down: three instances cover the
// PRESCALE=1/WRAP=0, PRESCALE=4 and WRAP=1 configurations.
module tb_counter_2digit_down;

   logic       clock;
   logic       reset;
   logic       load;
   logic [3:0] load_dig1;
   logic [3:0] load_dig0;
   logic       enable;

   logic [3:0] a_dig1, a_dig0, b_dig1, b_dig0, c_dig1, c_dig0;
   logic       a_zero, a_done, b_zero, b_done, c_zero, c_done;

   int n_cmp;
   int n_bad;

   counter_2digit_down #(.PRESCALE(1), .WRAP(1'b0)) u_a (
      .clock(clock), .reset(reset), .load(load), .load_dig1(load_dig1),
      .load_dig0(load_dig0), .enable(enable), .dig1(a_dig1), .dig0(a_dig0),
      .zero(a_zero), .done(a_done));

   counter_2digit_down #(.PRESCALE(4), .WRAP(1'b0)) u_b (
      .clock(clock), .reset(reset), .load(load), .load_dig1(load_dig1),
      .load_dig0(load_dig0), .enable(enable), .dig1(b_dig1), .dig0(b_dig0),
      .zero(b_zero), .done(b_done));

   counter_2digit_down #(.PRESCALE(1), .WRAP(1'b1)) u_c (
      .clock(clock), .reset(reset), .load(load), .load_dig1(load_dig1),
      .load_dig0(load_dig0), .enable(enable), .dig1(c_dig1), .dig0(c_dig0),
      .zero(c_zero), .done(c_done));

   initial clock = 1'b0;
   always #10 clock = ~clock;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [3:0] d1, input logic [3:0] d0);
      load = 1'b1; load_dig1 = d1; load_dig0 = d0;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; load = 1'b0; enable = 1'b0;
      load_dig1 = 4'd0; load_dig0 = 4'd0;
      #50;
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h00) begin
         n_bad++; $display("FAIL reset_digits_during got=%h want=00", {a_dig1, a_dig0});
      end
      n_cmp++;
      if ({a_zero, a_done} !== 2'b10) begin
         n_bad++; $display("FAIL reset_flags_during got zero=%b done=%b want zero=1 done=0", a_zero, a_done);
      end
      #50;
      reset = 1'b0;
      tick();
      n_cmp++;
      if ({b_dig1, b_dig0, c_dig1, c_dig0} !== 16'h0000 || b_zero !== 1'b1 || c_done !== 1'b0) begin
         n_bad++; $display("FAIL reset_after_release got b=%h c=%h bz=%b cd=%b want 00 00 1 0",
                           {b_dig1, b_dig0}, {c_dig1, c_dig0}, b_zero, c_done);
      end
   endtask

   task automatic test_basic_countdown();
      do_load(4'd1, 4'd2);
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h12 || a_done !== 1'b0) begin
         n_bad++; $display("FAIL basic_load got=%h done=%b want=12 done=0", {a_dig1, a_dig0}, a_done);
      end
      enable = 1'b1;
      for (int v = 11; v >= 0; v--) begin
         tick();
         n_cmp++;
         if ({a_dig1, a_dig0} !== to_bcd(v) || a_done !== (v == 0) || a_zero !== (v == 0)) begin
            n_bad++; $display("FAIL basic_step got=%h done=%b zero=%b want=%h done=%b",
                              {a_dig1, a_dig0}, a_done, a_zero, to_bcd(v), (v == 0));
         end
      end
      tick();
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h00 || a_done !== 1'b0 || a_zero !== 1'b1) begin
         n_bad++; $display("FAIL basic_hold got=%h done=%b zero=%b want=00 done=0 zero=1",
                           {a_dig1, a_dig0}, a_done, a_zero);
      end
      enable = 1'b0;
   endtask

   task automatic test_prescale_gating();
      enable = 1'b0;
      do_load(4'd0, 4'd5);
      enable = 1'b1;
      tick(); tick();
      enable = 1'b0;
      tick(); tick(); tick();
      enable = 1'b1;
      tick();
      n_cmp++;
      if ({b_dig1, b_dig0} !== 8'h05) begin
         n_bad++; $display("FAIL prescale_before_step got=%h want=05", {b_dig1, b_dig0});
      end
      tick();
      n_cmp++;
      if ({b_dig1, b_dig0} !== 8'h04 || b_done !== 1'b0) begin
         n_bad++; $display("FAIL prescale_step7 got=%h done=%b want=04 done=0", {b_dig1, b_dig0}, b_done);
      end
      tick(); tick(); tick();
      n_cmp++;
      if ({b_dig1, b_dig0} !== 8'h04) begin
         n_bad++; $display("FAIL prescale_period_early got=%h want=04", {b_dig1, b_dig0});
      end
      tick();
      n_cmp++;
      if ({b_dig1, b_dig0} !== 8'h03) begin
         n_bad++; $display("FAIL prescale_period got=%h want=03", {b_dig1, b_dig0});
      end
      enable = 1'b0;
   endtask

   task automatic test_wrap();
      do_load(4'd0, 4'd1);
      enable = 1'b1;
      tick();
      n_cmp++;
      if ({c_dig1, c_dig0} !== 8'h00 || c_done !== 1'b1 || c_zero !== 1'b1) begin
         n_bad++; $display("FAIL wrap_first_zero got=%h done=%b zero=%b want=00 done=1 zero=1",
                           {c_dig1, c_dig0}, c_done, c_zero);
      end
      tick();
      n_cmp++;
      if ({c_dig1, c_dig0} !== 8'h99 || c_done !== 1'b0) begin
         n_bad++; $display("FAIL wrap_to_99 got=%h done=%b want=99 done=0", {c_dig1, c_dig0}, c_done);
      end
      for (int v = 98; v >= 1; v--) begin
         tick();
         n_cmp++;
         if ({c_dig1, c_dig0} !== to_bcd(v) || c_done !== 1'b0) begin
            n_bad++; $display("FAIL wrap_count got=%h done=%b want=%h done=0",
                              {c_dig1, c_dig0}, c_done, to_bcd(v));
         end
      end
      tick();
      n_cmp++;
      if ({c_dig1, c_dig0} !== 8'h00 || c_done !== 1'b1) begin
         n_bad++; $display("FAIL wrap_second_done got=%h done=%b want=00 done=1", {c_dig1, c_dig0}, c_done);
      end
      enable = 1'b0;
   endtask

   task automatic test_clamp_collision();
      do_load(4'hC, 4'hF);
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h99) begin
         n_bad++; $display("FAIL clamp got=%h want=99", {a_dig1, a_dig0});
      end
      do_load(4'd0, 4'd2);
      enable = 1'b1;
      tick();
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h01) begin
         n_bad++; $display("FAIL collision_pre got=%h want=01", {a_dig1, a_dig0});
      end
      do_load(4'd3, 4'd0);
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h30 || a_done !== 1'b0) begin
         n_bad++; $display("FAIL collision_load got=%h done=%b want=30 done=0", {a_dig1, a_dig0}, a_done);
      end
      enable = 1'b0;
      do_load(4'd0, 4'd0);
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h00 || a_done !== 1'b0 || a_zero !== 1'b1) begin
         n_bad++; $display("FAIL load_zero got=%h done=%b zero=%b want=00 done=0 zero=1",
                           {a_dig1, a_dig0}, a_done, a_zero);
      end
   endtask

   task automatic test_async_reset();
      enable = 1'b0;
      do_load(4'd5, 4'd7);
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h57) begin
         n_bad++; $display("FAIL async_pre got=%h want=57", {a_dig1, a_dig0});
      end
      #5 reset = 1'b1;
      #1;
      n_cmp++;
      if ({a_dig1, a_dig0} !== 8'h00 || a_done !== 1'b0 || a_zero !== 1'b1) begin
         n_bad++; $display("FAIL async_reset got=%h done=%b zero=%b want=00 done=0 zero=1",
                           {a_dig1, a_dig0}, a_done, a_zero);
      end
      #2 reset = 1'b0;
      do_load(4'd0, 4'd1);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      n_cmp++;
      if (a_done !== 1'b1) begin
         n_bad++; $display("FAIL async_done_setup got done=%b want=1", a_done);
      end
      #5 reset = 1'b1;
      #1;
      n_cmp++;
      if (a_done !== 1'b0 || {a_dig1, a_dig0} !== 8'h00) begin
         n_bad++; $display("FAIL async_done_cancel got done=%b dig=%h want done=0 dig=00", a_done, {a_dig1, a_dig0});
      end
      #2 reset = 1'b0;
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_basic_countdown();
      test_prescale_gating();
      test_wrap();
      test_clamp_collision();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
